// File: rtl/demod_pkg.sv
// Shared types and default constants for the 4-level demodulator frame controller.
package demod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    typedef logic [1:0] sym_t;
    typedef logic [7:0] byte_t;

    localparam int          DEF_SYMBOL_DIV = 128;
    localparam logic [15:0] DEF_SYNC_WORD  = 16'hB4E1;

endpackage

// File: rtl/demod_frame_ctrl_symbol_timer.sv
// Symbol phase counter: symbol strobe, two mid-symbol sample pulses and the
// capture enable that marks phase 0 following a strobe. All outputs registered.
module symbol_timer
    import demod_pkg::*;
#(
    parameter int SYMBOL_DIV = DEF_SYMBOL_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic sym_strobe,
    output logic sample_a,
    output logic sample_b,
    output logic cap_en
);

    localparam int PW = $clog2(SYMBOL_DIV);
    typedef logic [PW-1:0] phase_t;

    localparam phase_t PH_LAST = phase_t'(SYMBOL_DIV - 1);
    localparam phase_t PH_A    = phase_t'(SYMBOL_DIV / 8);
    localparam phase_t PH_B    = phase_t'((3 * SYMBOL_DIV) / 8);

    phase_t phase;
    phase_t phase_next;

    // SYMBOL_DIV is a power of two, so the counter wraps on its own.
    always_comb begin
        phase_next = enable ? phase + phase_t'(1) : '0;
    end

    // Pulses are decoded from phase_next so each one lines up with the
    // registered phase value it names.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= '0;
            sym_strobe <= 1'b0;
            sample_a   <= 1'b0;
            sample_b   <= 1'b0;
            cap_en     <= 1'b0;
        end else begin
            phase      <= phase_next;
            sym_strobe <= (phase_next == PH_LAST);
            sample_a   <= (phase_next == PH_A);
            sample_b   <= (phase_next == PH_B);
            cap_en     <= enable && (phase == PH_LAST);
        end
    end

endmodule

// File: rtl/demod_frame_ctrl.sv
// Frame controller: sync hunt, payload byte packing and single-entry byte stream.
// DEMOD_CTRL_TIMEOUT_EN adds the identical-symbol run abort (frame_abort).
module demod_frame_ctrl
    import demod_pkg::*;
#(
    parameter int          SYMBOL_DIV    = DEF_SYMBOL_DIV,
    parameter logic [15:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter int          PAYLOAD_BYTES = 16
`ifdef DEMOD_CTRL_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_SYMS  = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] sym_in,
    output logic       sym_strobe,
    output logic       sample_a,
    output logic       sample_b,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       frame_done,
    output logic       frame_abort,
    output logic       overflow
);

    // state      | meaning
    // ST_IDLE    | disabled; frame counters cleared
    // ST_HUNT    | shifting symbols, looking for the 8-symbol sync word
    // ST_PAYLOAD | packing 4 symbols per byte into the output register
    // ST_DONE    | one-cycle frame_done pulse, then back to hunting

    localparam byte_t PAYLOAD_LAST = byte_t'(PAYLOAD_BYTES - 1);

    state_t      state;
    logic [15:0] sr;
    logic [3:0]  hunt_cnt;
    logic [5:0]  pack;
    logic [1:0]  sym_idx;
    byte_t       byte_cnt;
    logic        cap_en;
    logic        abort_hit;

    logic [15:0] sr_next;
    byte_t       byte_next;

    assign sr_next   = {sr[13:0], sym_in};
    assign byte_next = {pack, sym_in};

    symbol_timer #(
        .SYMBOL_DIV(SYMBOL_DIV)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sym_strobe(sym_strobe),
        .sample_a  (sample_a),
        .sample_b  (sample_b),
        .cap_en    (cap_en)
    );

`ifdef DEMOD_CTRL_TIMEOUT_EN
    localparam int RUN_W = $clog2(TIMEOUT_SYMS + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(TIMEOUT_SYMS);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    sym_t             last_sym;

    // run_cnt==0 means no payload symbol seen yet, so the first one starts a run of 1.
    always_comb begin
        run_next  = ((run_cnt != '0) && (sym_in == last_sym)) ? run_cnt + RUN_W'(1) : RUN_W'(1);
        abort_hit = cap_en && (state == ST_PAYLOAD) && (run_next == RUN_LIMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt     <= '0;
            last_sym    <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= abort_hit;
            if (state != ST_PAYLOAD) begin
                run_cnt <= '0;
            end else if (cap_en) begin
                run_cnt  <= run_next;
                last_sym <= sym_in;
            end
        end
    end
`else
    assign abort_hit   = 1'b0;
    assign frame_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sr          <= '0;
            hunt_cnt    <= '0;
            pack        <= '0;
            sym_idx     <= '0;
            byte_cnt    <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            overflow    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            // Handshake runs in every state; a load below overrides the clear.
            if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end

            if (!enable) begin
                state    <= ST_IDLE;
                sr       <= '0;
                hunt_cnt <= '0;
                pack     <= '0;
                sym_idx  <= '0;
                byte_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_HUNT;
                        sr       <= '0;
                        hunt_cnt <= '0;
                    end
                    ST_HUNT: begin
                        if (cap_en) begin
                            sr <= sr_next;
                            if (hunt_cnt != 4'd8) begin
                                hunt_cnt <= hunt_cnt + 4'd1;
                            end
                            if ((sr_next == SYNC_WORD) && (hunt_cnt >= 4'd7)) begin
                                state       <= ST_PAYLOAD;
                                frame_start <= 1'b1;
                                pack        <= '0;
                                sym_idx     <= '0;
                                byte_cnt    <= '0;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (cap_en) begin
                            if (abort_hit) begin
                                state    <= ST_HUNT;
                                sr       <= '0;
                                hunt_cnt <= '0;
                                pack     <= '0;
                                sym_idx  <= '0;
                                byte_cnt <= '0;
                            end else begin
                                pack    <= byte_next[5:0];
                                sym_idx <= sym_idx + 2'd1;
                                if (sym_idx == 2'd3) begin
                                    if (!byte_valid || byte_ready) begin
                                        byte_data  <= byte_next;
                                        byte_valid <= 1'b1;
                                    end else begin
                                        overflow <= 1'b1;
                                    end
                                    byte_cnt <= byte_cnt + 8'd1;
                                    if (byte_cnt == PAYLOAD_LAST) begin
                                        state <= ST_DONE;
                                    end
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        frame_done <= 1'b1;
                        state      <= ST_HUNT;
                        sr         <= '0;
                        hunt_cnt   <= '0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demod_frame_ctrl.sv
// Directed bench for demod_frame_ctrl: timing, framing, early sync, backpressure,
// disable/re-enable and the run-length timeout (behaviour follows DEMOD_CTRL_TIMEOUT_EN).
module tb_demod_frame_ctrl;

    localparam int DIV = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] sym_in = 2'd0;
    logic       byte_ready = 1'b1;
    logic       sym_strobe, sample_a, sample_b;
    logic [7:0] byte_data;
    logic       byte_valid, frame_start, frame_done, frame_abort, overflow;

    int n_chk = 0;
    int n_bad = 0;

    int         cyc = 0;
    int         n_start = 0, n_done = 0, n_abort = 0, n_strobe = 0;
    int         t_bv = 0, t_done = 0;
    logic       bv_q = 1'b0;
    logic [7:0] acc[$];

    always #5 clk = ~clk;

    demod_frame_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sym_in     (sym_in),
        .sym_strobe (sym_strobe),
        .sample_a   (sample_a),
        .sample_b   (sample_b),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .overflow   (overflow)
    );

    // Samples pre-edge values: events, accepted bytes and latency stamps.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (frame_start) n_start = n_start + 1;
        if (frame_done) begin
            n_done = n_done + 1;
            t_done = cyc;
        end
        if (frame_abort) n_abort = n_abort + 1;
        if (sym_strobe) n_strobe = n_strobe + 1;
        if (byte_valid && byte_ready) acc.push_back(byte_data);
        if (byte_valid && !bv_q) t_bv = cyc;
        bv_q = byte_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a symbol during the strobe cycle; it is captured one cycle later.
    task automatic send_sym(input logic [1:0] s);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sym_strobe && k < 2 * DIV);
        if (!sym_strobe) chk("strobe_wait", 32'd0, 32'd1);
        sym_in = s;
    endtask

    task automatic send_sync();
        logic [15:0] sw;
        sw = 16'hB4E1;
        for (int i = 0; i < 8; i++) send_sym(sw[15-2*i -: 2]);
    endtask

    // Sends n symbols, cycling through the four 2-bit fields of pat MSB-first.
    task automatic send_pattern(input int n, input logic [7:0] pat);
        for (int i = 0; i < n; i++) send_sym(pat[7-2*(i%4) -: 2]);
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [7:0] v);
        chk({tag, "_count"}, acc.size(), n);
        for (int i = 0; i < acc.size() && i < n; i++) chk({tag, "_byte"}, acc[i], v);
    endtask

    initial begin
        int p_str0, p_str1, p_sa, p_sb, n_str, s0, d0, a0;
        logic [1:0] part[6];

        repeat (3) @(negedge clk);
        chk("reset_outs", {sym_strobe, sample_a, sample_b, byte_valid, byte_data,
                           frame_start, frame_done, frame_abort, overflow}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outs", {sym_strobe, sample_a, sample_b, byte_valid, overflow}, 32'd0);

        // Timing: enable rises in period 1; strobe lands in period 128, 256.
        enable = 1'b1;
        p_str0 = 0; p_str1 = 0; p_sa = 0; p_sb = 0; n_str = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (sym_strobe) begin
                if (n_str == 0) p_str0 = k + 1;
                else if (n_str == 1) p_str1 = k + 1;
                n_str++;
            end
            if (sample_a && p_sa == 0) p_sa = k + 1;
            if (sample_b && p_sb == 0) p_sb = k + 1;
        end
        chk("strobe_first", p_str0, 128);
        chk("strobe_second", p_str1, 256);
        chk("strobe_count", n_str, 2);
        chk("sample_a_phase", p_sa - 1, 16);
        chk("sample_b_phase", p_sb - 1, 48);

        // Framing: sync then 64 symbols 0,1,2,3 -> 16 x 8'h1B.
        acc.delete();
        s0 = n_start; d0 = n_done;
        send_sync();
        send_pattern(64, 8'h1B);
        repeat (8) @(negedge clk);
        chk("frame_start_cnt", n_start - s0, 1);
        chk("frame_done_cnt", n_done - d0, 1);
        chk("done_latency", t_done - t_bv, 1);
        check_bytes("frame1", 16, 8'h1B);

        // Early sync: a partial pattern after a frame must not trigger.
        part = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
        s0 = n_start;
        for (int i = 0; i < 6; i++) send_sym(part[i]);
        repeat (4) @(negedge clk);
        chk("partial_no_start", n_start - s0, 0);
        send_sync();
        repeat (4) @(negedge clk);
        chk("full_sync_start", n_start - s0, 1);

        // Backpressure: two bytes with ready low -> first held, second dropped.
        acc.delete();
        byte_ready = 1'b0;
        send_pattern(4, 8'h1B);
        send_pattern(4, 8'hE4);
        repeat (8) @(negedge clk);
        chk("bp_valid_held", byte_valid, 1);
        chk("bp_data_held", byte_data, 8'h1B);
        chk("bp_overflow", overflow, 1);
        byte_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_valid_drop", byte_valid, 0);
        chk("bp_overflow_sticky", overflow, 1);
        check_bytes("bp", 1, 8'h1B);

        // Disable mid-payload: strobes stop, no done/abort.
        d0 = n_done; a0 = n_abort;
        @(negedge clk);
        enable = 1'b0;
        n_str = n_strobe;
        repeat (300) @(negedge clk);
        chk("dis_no_strobe", n_strobe - n_str, 0);
        chk("dis_no_done", n_done - d0, 0);
        chk("dis_no_abort", n_abort - a0, 0);
        enable = 1'b1;
        acc.delete();
        send_sync();
        send_pattern(64, 8'hE4);
        repeat (8) @(negedge clk);
        chk("reen_done", n_done - d0, 1);
        check_bytes("reen", 16, 8'hE4);

        // Run of 64 zero symbols in payload.
        acc.delete();
        d0 = n_done; a0 = n_abort;
        send_sync();
        send_pattern(64, 8'h00);
        repeat (8) @(negedge clk);
`ifdef DEMOD_CTRL_TIMEOUT_EN
        chk("to_abort", n_abort - a0, 1);
        chk("to_no_done", n_done - d0, 0);
        check_bytes("to", 7, 8'h00);
`else
        chk("to_abort", n_abort - a0, 0);
        chk("to_done", n_done - d0, 1);
        check_bytes("to", 16, 8'h00);
`endif

        // Asynchronous reset clears the sticky overflow and any pending byte.
        byte_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_overflow", overflow, 0);
        chk("rst_valid", byte_valid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/demod_frame_ctrl.md
# demod_frame_ctrl

Symbol-timing and frame controller for the 4-level demodulator. It generates the per-symbol strobe and the two mid-symbol sample strobes that the demodulator consumes, and captures each decoded 2-bit symbol. It hunts for a 16-bit sync word, then packs a fixed-length payload into bytes and delivers them over a valid/ready stream to the downstream byte sink.

## Interface
- SYMBOL_DIV, 128: clk cycles per symbol; power of two, ≥16.
- SYNC_WORD, 16'hB4E1: sync pattern (8 symbols, MSB-first).
- PAYLOAD_BYTES, 16: bytes per frame, 1..255.
- TIMEOUT_SYMS, 32: identical-symbol run length that aborts a frame (only with the config macro).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  run control; low forces IDLE.
- sym_in  in  2  decoded symbol from the demodulator.
- sym_strobe  out  1  one-cycle symbol boundary pulse; drives the demodulator's symbol clock.
- sample_a / sample_b  out  1  one-cycle sample pulses at SYMBOL_DIV/8 and 3*SYMBOL_DIV/8.
- byte_data  out  8  payload byte.
- byte_valid  out  1  byte_data is held stable while high.
- byte_ready  in  1  sink accepts when valid&&ready.
- frame_start / frame_done / frame_abort  out  1  one-cycle event pulses.
- overflow  out  1  sticky; set when a byte is dropped.

## Operation
- phase counter is $clog2(SYMBOL_DIV) bits wide. It counts 0..SYMBOL_DIV-1 and wraps while enable=1. It is held at 0 while enable=0.
- sym_strobe=1 exactly when phase==SYMBOL_DIV-1.
- sym_in is captured on the cycle phase==0 following a strobe. The demodulator updates on the strobe edge, so the value is settled by then. Each capture is one "symbol event".
- States: IDLE, HUNT, PAYLOAD, DONE.
- IDLE → HUNT: when enable=1. The sync shift register and hunt counter are cleared.
- HUNT, on each symbol event:
  - sr <= {sr[13:0], sym}; hunt_cnt saturates at 8.
  - If the new sr == SYNC_WORD and hunt_cnt≥7 (i.e., 8 symbols seen including this one) → PAYLOAD, with frame_start pulsed in the same cycle.
- PAYLOAD, on each symbol event:
  - Shift the symbol into a 4-symbol packer; the first symbol lands in bits[7:6].
  - On the 4th symbol, present the byte, then increment byte_cnt.
  - When byte_cnt reaches PAYLOAD_BYTES → DONE.
- DONE: lasts one cycle. Pulse frame_done, then → HUNT with sr cleared.
- Output register is single-entry:
  - If a byte completes while byte_valid=1 and byte_ready=0, the new byte is dropped and overflow is set.
  - If byte_ready=1 in that same cycle, the accept and the load happen together with no drop.
- enable falls in any state: → IDLE next cycle.
  - Frame counters are cleared; no frame_done or frame_abort is pulsed.
  - A pending byte_valid stays until it is accepted.
- overflow clears only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, phase 0.
- First sym_strobe comes SYMBOL_DIV cycles after enable rises; strobes then repeat every SYMBOL_DIV cycles.
- Symbol capture occurs 1 cycle after sym_strobe.
- frame_start asserts in the capture cycle of the last sync symbol.
- byte_valid rises in the capture cycle of the byte's 4th symbol (combinational-free, registered).
- frame_done follows the last byte's capture by 1 cycle.
- A handshake completes on any clk edge with valid&&ready; byte_valid drops the next cycle unless a new byte is loaded.
- Reset mid-frame: immediate asynchronous return to reset values, and any pending byte is lost.

## Configuration
- DEMOD_CTRL_TIMEOUT_EN defined:
  - In PAYLOAD, count consecutive identical symbols.
  - Reaching TIMEOUT_SYMS → HUNT, with frame_abort pulsed for one cycle.
  - The partial byte is discarded; bytes already delivered stand.
- Not defined: frame_abort is tied 0 and no run counter is synthesised.

## Structure
- Shared package demod_pkg holds:
  - the state enum;
  - the sym_t (2-bit) and byte_t typedefs;
  - default SYNC_WORD and SYMBOL_DIV constants.
- One sub-module, symbol_timer: the phase counter plus strobe/sample/capture-enable generation, parameterised by SYMBOL_DIV. The frame FSM and byte output stay in the top.

## Test plan
- Timing: enable=1 with SYMBOL_DIV=128 → sym_strobe at cycles 128, 256, …; sample_a at phase 16; sample_b at phase 48.
- Framing: feed symbols 2,3,1,0,3,2,0,1 (0xB4E1) then 64 payload symbols 0,1,2,3 repeated → frame_start once, 16 bytes of 8'h1B with byte_ready=1, frame_done 1 cycle after the last byte, state back to HUNT.
- Early sync: sync pattern presented before 8 symbols have been seen since enable (preload via partial pattern) → no frame_start until a full 8-symbol match.
- Backpressure: byte_ready=0 across two byte completions → first byte held, second dropped, overflow=1 and stays 1 after ready returns.
- Disable: enable=0 mid-PAYLOAD → IDLE next cycle, strobes stop, no frame_done; re-enable, then a full frame is received correctly.
- Timeout: with DEMOD_CTRL_TIMEOUT_EN, 32 consecutive symbols of 2'b00 in PAYLOAD → frame_abort pulse, then HUNT; without the macro → frame completes normally.
